// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Slot extraction supports up to VEC_W bits of packed operands, SLOT_W bits per slot.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam int SLOT_W = 8;
    localparam int VEC_W  = 32;

    localparam logic [SLOT_W-1:0] REG_ZERO = '0;

    // Caller truncates the result to its own register-address width.
    function automatic logic [SLOT_W-1:0] src_slot(
        input logic [VEC_W-1:0] vec,
        input int unsigned      i,
        input int unsigned      aw
    );
        return SLOT_W'(vec >> (i * aw));
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand bypass select: MEM result beats WB result, register 0 never forwards.
// Purely combinational, no latency, no backpressure.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rd_m,
    input  logic          regwrite_m,
    input  logic [AW-1:0] rd_w,
    input  logic          regwrite_w,
    output fwd_sel_t      sel
);

    logic hit_m;
    logic hit_w;

    assign hit_m = regwrite_m && (rd_m != AW'(REG_ZERO)) && (rd_m == rs);
    assign hit_w = regwrite_w && (rd_w != AW'(REG_ZERO)) && (rd_w == rs);

    always_comb begin
        sel = FWD_RF;
        if (hit_m) begin
            sel = FWD_MEM;
        end else if (hit_w) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_n.sv
// Forwarding, load-use/long-op stall, branch flush and single-entry long-op scoreboard.
// Controls are combinational (zero latency); stall_f/stall_d are the backpressure to fetch/decode.
module hazard_ctrl_n
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int AW       = 5,
    parameter int LONG_LAT = 4,
    parameter int CW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC*AW-1:0] rs_d,
    input  logic [NUM_SRC-1:0]    rs_used_d,
    input  logic [AW-1:0]         rd_d,
    input  logic                  regwrite_d,
    input  logic                  long_d,
    input  logic [NUM_SRC*AW-1:0] rs_e,
    input  logic [AW-1:0]         rd_e,
    input  logic                  memread_e,
    input  logic                  long_issue_e,
    input  logic                  branch_taken_e,
    input  logic [AW-1:0]         rd_m,
    input  logic [AW-1:0]         rd_w,
    input  logic                  regwrite_m,
    input  logic                  regwrite_w,
    output logic [NUM_SRC*2-1:0]  fwd_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  long_busy,
    output logic                  long_wb_valid,
    output logic [AW-1:0]         long_wb_rd
);

    logic          pend_valid;
    logic [AW-1:0] pend_rd;
    logic [CW-1:0] cnt;

    logic          wb_now;
    logic [AW-1:0] rs_d_slot [NUM_SRC];
    logic [AW-1:0] rs_e_slot [NUM_SRC];
    fwd_sel_t      fwd_sel   [NUM_SRC];

    logic match_e;
    logic match_pend;
    logic lu;
    logic lh;
    logic raw_hz;
    logic waw_hz;
    logic struct_hz;
    logic sb;
    logic hz;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            assign rs_d_slot[gi] = AW'(src_slot(VEC_W'(rs_d), gi, AW));
            assign rs_e_slot[gi] = AW'(src_slot(VEC_W'(rs_e), gi, AW));

            fwd_select #(
                .AW(AW)
            ) u_fwd (
                .rs         (rs_e_slot[gi]),
                .rd_m       (rd_m),
                .regwrite_m (regwrite_m),
                .rd_w       (rd_w),
                .regwrite_w (regwrite_w),
                .sel        (fwd_sel[gi])
            );

            assign fwd_e[gi*2 +: 2] = rst ? FWD_RF : fwd_sel[gi];
        end
    endgenerate

    // Scoreboard: one long op in flight; issue while busy is ignored.
    assign wb_now = pend_valid && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            cnt        <= '0;
        end else if (pend_valid) begin
            if (cnt == '0) begin
                pend_valid <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (long_issue_e) begin
            pend_valid <= 1'b1;
            pend_rd    <= rd_e;
            cnt        <= CW'(LONG_LAT - 1);
        end
    end

    always_comb begin
        match_e    = 1'b0;
        match_pend = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_used_d[i] && (rs_d_slot[i] == rd_e)) begin
                match_e = 1'b1;
            end
            if (rs_used_d[i] && (rs_d_slot[i] == pend_rd)) begin
                match_pend = 1'b1;
            end
        end
    end

    assign lu        = memread_e && (rd_e != AW'(REG_ZERO)) && match_e;
    assign lh        = long_issue_e && (rd_e != AW'(REG_ZERO)) && match_e;
    assign raw_hz    = pend_valid && (pend_rd != AW'(REG_ZERO)) && match_pend;
    assign waw_hz    = pend_valid && regwrite_d && (rd_d == pend_rd);
    assign struct_hz = long_d && (pend_valid || long_issue_e);
    // Regfile writes in the first half-cycle, so Decode sees the long result on the pulse.
    assign sb        = (raw_hz || waw_hz || struct_hz) && !wb_now;
    assign hz        = lu || lh || sb;

    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        long_busy     = 1'b0;
        long_wb_valid = 1'b0;
        long_wb_rd    = '0;
        if (!rst) begin
            // A taken branch makes the Decode instruction wrong-path, so its hazard is moot.
            if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                stall_f = hz;
                stall_d = hz;
                flush_e = hz;
            end
            long_busy     = pend_valid;
            long_wb_valid = wb_now;
            long_wb_rd    = pend_rd;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_n.sv
// Directed vectors for hazard_ctrl_n; expected outputs queued per cycle, checked by a negedge monitor.
module tb_hazard_ctrl_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rs_d;
    logic [1:0] rs_used_d;
    logic [4:0] rd_d;
    logic       regwrite_d;
    logic       long_d;
    logic [9:0] rs_e;
    logic [4:0] rd_e;
    logic       memread_e;
    logic       long_issue_e;
    logic       branch_taken_e;
    logic [4:0] rd_m;
    logic [4:0] rd_w;
    logic       regwrite_m;
    logic       regwrite_w;
    logic [3:0] fwd_e;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic       long_busy;
    logic       long_wb_valid;
    logic [4:0] long_wb_rd;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [3:0] C_NONE   = 4'b0000;
    localparam logic [3:0] C_STALL  = 4'b1101;
    localparam logic [3:0] C_BRANCH = 4'b0011;

    typedef struct {
        string      nm;
        logic [3:0] fwd;
        logic [3:0] ctl;
        logic       busy;
        logic       wbv;
        logic [4:0] rd;
        bit         crd;
    } exp_t;

    exp_t exp_q[$];

    hazard_ctrl_n #(
        .NUM_SRC  (2),
        .AW       (5),
        .LONG_LAT (4),
        .CW       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rs_d           (rs_d),
        .rs_used_d      (rs_used_d),
        .rd_d           (rd_d),
        .regwrite_d     (regwrite_d),
        .long_d         (long_d),
        .rs_e           (rs_e),
        .rd_e           (rd_e),
        .memread_e      (memread_e),
        .long_issue_e   (long_issue_e),
        .branch_taken_e (branch_taken_e),
        .rd_m           (rd_m),
        .rd_w           (rd_w),
        .regwrite_m     (regwrite_m),
        .regwrite_w     (regwrite_w),
        .fwd_e          (fwd_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .long_busy      (long_busy),
        .long_wb_valid  (long_wb_valid),
        .long_wb_rd     (long_wb_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(long_issue_e && long_busy))
                else $error("protocol violation: long issue while busy");
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (fwd_e === e.fwd)
              && ({stall_f, stall_d, flush_d, flush_e} === e.ctl)
              && (long_busy === e.busy)
              && (long_wb_valid === e.wbv)
              && (!e.crd || (long_wb_rd === e.rd));
            n_total++;
            if (ok) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got fwd=%b sf/sd/fd/fe=%b busy=%b wbv=%b rd=%0d, want fwd=%b sf/sd/fd/fe=%b busy=%b wbv=%b rd=%0d(chk=%0d)",
                         e.nm, fwd_e, {stall_f, stall_d, flush_d, flush_e}, long_busy,
                         long_wb_valid, long_wb_rd, e.fwd, e.ctl, e.busy, e.wbv, e.rd, e.crd);
            end
        end
    end

    task automatic idle_inputs();
        rs_d           = '0;
        rs_used_d      = '0;
        rd_d           = '0;
        regwrite_d     = 1'b0;
        long_d         = 1'b0;
        rs_e           = '0;
        rd_e           = '0;
        memread_e      = 1'b0;
        long_issue_e   = 1'b0;
        branch_taken_e = 1'b0;
        rd_m           = '0;
        rd_w           = '0;
        regwrite_m     = 1'b0;
        regwrite_w     = 1'b0;
    endtask

    // Queue the expectation for the inputs just driven, then advance one cycle.
    task automatic chk(input string nm, input logic [3:0] fwd, input logic [3:0] ctl,
                       input logic busy, input logic wbv, input logic [4:0] rd, input bit crd);
        exp_t e;
        e.nm   = nm;
        e.fwd  = fwd;
        e.ctl  = ctl;
        e.busy = busy;
        e.wbv  = wbv;
        e.rd   = rd;
        e.crd  = crd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset forces every output low even with hazards present
        rs_e = {5'd0, 5'd5}; rd_m = 5'd5; regwrite_m = 1'b1;
        memread_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0}; rs_used_d = 2'b10;
        branch_taken_e = 1'b1;
        chk("rst_outputs", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b1);
        rst = 1'b0;
        idle_inputs();
        chk("reset_state", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b1);

        // Forwarding
        rs_e = {5'd0, 5'd5}; rd_m = 5'd5; rd_w = 5'd5; regwrite_m = 1'b1; regwrite_w = 1'b1;
        chk("fwd_mem_prio", 4'b0010, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        regwrite_m = 1'b0;
        chk("fwd_wb", 4'b0001, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        regwrite_m = 1'b1; rd_m = 5'd0; rd_w = 5'd0; rs_e = '0;
        chk("fwd_r0", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        rs_e = {5'd6, 5'd3}; rd_m = 5'd6; rd_w = 5'd3;
        chk("fwd_two_slots", 4'b1001, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        idle_inputs();

        // Load-use
        memread_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0}; rs_used_d = 2'b10;
        chk("lu_stall", 4'b0000, C_STALL, 1'b0, 1'b0, 5'd0, 1'b0);
        rs_used_d = 2'b01;
        chk("lu_unused_src", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        rd_e = 5'd0; rs_d = '0; rs_used_d = 2'b11;
        chk("lu_rd0", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        rd_e = 5'd7; rs_d = {5'd7, 5'd0}; rs_used_d = 2'b10; branch_taken_e = 1'b1;
        chk("branch_over_lu", 4'b0000, C_BRANCH, 1'b0, 1'b0, 5'd0, 1'b0);
        idle_inputs();

        // Long op to x9, consumer in slot 0 from the issue cycle on
        long_issue_e = 1'b1; rd_e = 5'd9; rs_d = {5'd0, 5'd9}; rs_used_d = 2'b01;
        chk("long_lh_c0", 4'b0000, C_STALL, 1'b0, 1'b0, 5'd0, 1'b0);
        long_issue_e = 1'b0; rd_e = 5'd0;
        chk("long_raw_c1", 4'b0000, C_STALL, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("long_raw_c2", 4'b0000, C_STALL, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("long_raw_c3", 4'b0000, C_STALL, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("long_wb_c4", 4'b0000, C_NONE, 1'b1, 1'b1, 5'd9, 1'b1);
        chk("long_idle_c5", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        idle_inputs();

        // Structural / WAW while busy, then back-to-back issue with long_d
        long_issue_e = 1'b1; rd_e = 5'd9;
        chk("sw_issue", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        idle_inputs();
        long_d = 1'b1;
        chk("sw_struct", 4'b0000, C_STALL, 1'b1, 1'b0, 5'd0, 1'b0);
        long_d = 1'b0; regwrite_d = 1'b1; rd_d = 5'd9;
        chk("sw_waw", 4'b0000, C_STALL, 1'b1, 1'b0, 5'd0, 1'b0);
        rd_d = 5'd3;
        chk("sw_no_match", 4'b0000, C_NONE, 1'b1, 1'b0, 5'd0, 1'b0);
        regwrite_d = 1'b0; long_d = 1'b1;
        chk("sw_wb_suppress", 4'b0000, C_NONE, 1'b1, 1'b1, 5'd9, 1'b1);
        long_issue_e = 1'b1; rd_e = 5'd4;
        chk("sw_long_d_issue", 4'b0000, C_STALL, 1'b0, 1'b0, 5'd0, 1'b0);
        idle_inputs();
        chk("sw2_c1", 4'b0000, C_NONE, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("sw2_c2", 4'b0000, C_NONE, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("sw2_c3", 4'b0000, C_NONE, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("sw2_wb", 4'b0000, C_NONE, 1'b1, 1'b1, 5'd4, 1'b1);
        chk("sw2_idle", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);

        // Long op to x0 pulses writeback but never stalls a read of x0
        long_issue_e = 1'b1; rd_e = 5'd0;
        chk("r0_issue", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        idle_inputs();
        rs_used_d = 2'b01;
        chk("r0_c1", 4'b0000, C_NONE, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("r0_c2", 4'b0000, C_NONE, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("r0_c3", 4'b0000, C_NONE, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("r0_wb", 4'b0000, C_NONE, 1'b1, 1'b1, 5'd0, 1'b1);
        chk("r0_idle", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        idle_inputs();

        // Reset mid-op discards the pending writeback
        long_issue_e = 1'b1; rd_e = 5'd9;
        chk("rm_issue", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        idle_inputs();
        chk("rm_busy", 4'b0000, C_NONE, 1'b1, 1'b0, 5'd0, 1'b0);
        rst = 1'b1; rs_d = {5'd0, 5'd9}; rs_used_d = 2'b01; branch_taken_e = 1'b1;
        rs_e = {5'd0, 5'd5}; rd_m = 5'd5; regwrite_m = 1'b1;
        chk("rm_rst_zero", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b1);
        rst = 1'b0;
        idle_inputs();
        chk("rm_after_c3", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("rm_after_c4", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("rm_after_c5", 4'b0000, C_NONE, 1'b0, 1'b0, 5'd0, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_n.md
Name: hazard_ctrl_n

Overview:
Parametrised pipeline hazard controller for the 5-stage core, replacing the fixed 2-source forwarding-only unit. It provides forwarding selects for NUM_SRC Execute operands and load-use stall/bubble detection in Decode. It also handles taken-branch flush and a scoreboard for one outstanding fixed-latency long operation (MUL/DIV), including timing its writeback. It sits between the pipeline registers and the datapath muxes; all control outputs are combinational from inputs plus registered scoreboard state.

Parameters:
NUM_SRC, 2, number of source operands per instruction (1..4)
AW, 5, register address width; register 0 is hardwired zero
LONG_LAT, 4, long-unit latency in cycles from issue to writeback (1..15)
CW, 4, scoreboard counter width; must satisfy 2**CW > LONG_LAT

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
rs_d  in  NUM_SRC*AW  Decode source addresses; slot i at [i*AW +: AW]
rs_used_d  in  NUM_SRC  per-slot "source actually read" in Decode
rd_d  in  AW  Decode destination
regwrite_d  in  1  Decode instruction writes rd_d
long_d  in  1  Decode instruction is a long op
rs_e  in  NUM_SRC*AW  Execute source addresses
rd_e  in  AW  Execute destination
memread_e  in  1  Execute instruction is a load
long_issue_e  in  1  Execute instruction is a valid long op issuing this cycle
branch_taken_e  in  1  taken branch/jump resolved in Execute
rd_m, rd_w  in  AW  Memory/Writeback destinations
regwrite_m, regwrite_w  in  1  Memory/Writeback write enables
fwd_e  out  NUM_SRC*2  per-slot forward select: 00 regfile, 01 WB, 10 MEM
stall_f, stall_d  out  1  hold PC / hold IF-ID register
flush_d, flush_e  out  1  zero IF-ID / zero ID-EX register (bubble)
long_busy  out  1  long op outstanding
long_wb_valid  out  1  one-cycle pulse: long result writes back this cycle
long_wb_rd  out  AW  destination of the long writeback

Behaviour:
- Reset (rst=1 at posedge): pend_valid=0, pend_rd=0, cnt=0. While rst=1, all outputs are forced to 0 combinationally.
- Forwarding, per slot i:
  - 10 if regwrite_m, rd_m!=0 and rd_m==rs_e[i].
  - Else 01 if regwrite_w, rd_w!=0 and rd_w==rs_e[i].
  - Else 00. MEM has priority over WB.
- Load-use hazard (lu): memread_e and rd_e!=0 and some slot i has rs_used_d[i] with rs_d[i]==rd_e.
- Long-in-flight hazard (lh): long_issue_e and rd_e!=0 and some used rs_d[i]==rd_e (treated like load-use).
- Scoreboard hazard (sb): pend_valid and any of:
  - a used rs_d[i]==pend_rd (RAW);
  - regwrite_d and rd_d==pend_rd (WAW);
  - long_d (structural).
  Also asserted when long_d and long_issue_e in the same cycle.
- sb is suppressed in the cycle long_wb_valid=1. The register file writes in the first half-cycle, so Decode reads the new value.
- hz = lu | lh | sb.
- Branch: branch_taken_e drives flush_d=1 and flush_e=1, and forces stall_f=stall_d=0. Branch wins over hz because the Decode instruction is wrong-path.
- No branch: stall_f=stall_d=flush_e=hz; flush_d=0.
- Scoreboard sequencing:
  - On posedge with long_issue_e=1 and pend_valid=0: pend_valid<=1, pend_rd<=rd_e, cnt<=LONG_LAT-1.
  - While pend_valid and cnt!=0: cnt decrements.
  - When pend_valid and cnt==0: long_wb_valid=1, long_wb_rd=pend_rd; pend_valid<=0 at that edge.
  - Net latency: issue in cycle t gives the writeback pulse in cycle t+LONG_LAT.
- Writeback of a long op to rd=0 still pulses long_wb_valid; it never causes RAW stalls.
- long_issue_e while pend_valid=0 and long_wb_valid=1 cannot occur, because pend_valid=1 in that cycle.
- long_issue_e while pend_valid=1 is a protocol violation: state is unchanged and a bench assertion fires.
- long_busy=pend_valid. long_wb_rd holds pend_rd at all times and is meaningful only with long_wb_valid.
- Reset mid-operation discards the outstanding long op; no writeback pulse is produced.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_ZERO constant.
  - function src_slot(vec, i) for slot extraction.
- Sub-module fwd_select: one per slot via generate. Inputs rs, rd_m, regwrite_m, rd_w, regwrite_w; output fwd_sel_t.
- Scoreboard and hazard/flush logic stay in hazard_ctrl_n.

Test Plan:
- Forwarding priority: rs_e slot0=5, rd_m=5, rd_w=5, regwrite_m=regwrite_w=1 -> fwd slot0=10. Drop regwrite_m -> 01. Set rd_m=rd_w=0, rs_e=0 -> 00.
- Load-use: memread_e=1, rd_e=7, rs_d slot1=7, rs_used_d=2'b10 -> stall_f=stall_d=flush_e=1, flush_d=0. Same with rs_used_d=2'b01 -> no stall.
- Branch over stall: same as load-use plus branch_taken_e=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
- Long op, LONG_LAT=4: long_issue_e=1, rd_e=9 in cycle 0; Decode reads x9 from cycle 1.
  - stall_d=1 in cycles 1-3.
  - Cycle 4: long_wb_valid=1, long_wb_rd=9, stall_d=0.
  - Cycle 5: long_busy=0.
- Structural/WAW: while busy (rd 9), long_d=1 -> stall. regwrite_d=1, rd_d=9 -> stall. rd_d=3 with no source match -> no stall.
- Reset mid-op: rst=1 in cycle 2 after issue -> long_busy=0 next cycle, no long_wb_valid pulse ever, all outputs 0 while rst=1.
